// File: rtl/bsg_downstream_in.sv
// Link-side receiver: reassembles 4 two-byte beats into 64-bit words, buffers
// them in a small FIFO for the core and returns credit tokens per dequeue batch.
module bsg_downstream_in #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TOKEN_BATCH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_valid_in,
  input  logic [7:0]  io_data_in_ch0,
  input  logic [7:0]  io_data_in_ch1,
  output logic        io_token_out,
  output logic        core_valid_out,
  output logic [63:0] core_data_out,
  input  logic        core_yumi_in,
  output logic [6:0]  recv_cnt,
  output logic [1:0]  step,
  output logic        overflow_err
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int BWR = $clog2(TOKEN_BATCH + 1);
  localparam int BW  = (BWR > 2) ? BWR : 2;

  logic [1:0]    r_step;
  logic [47:0]   r_asm;
  logic [63:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [6:0]    r_recv_cnt;
  logic [BW-1:0] r_batch;
  logic          r_token;
  logic          r_overflow;

  logic          w_full;
  logic          w_empty;
  logic          w_beat3;
  logic          w_deq;
  logic          w_enq;
  logic [63:0]   w_word;
  logic [BW-1:0] w_batch_inc;
  logic          w_batch_wrap;

  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_beat3      = io_valid_in && (r_step == 2'd3);
  // A yumi on an empty FIFO is ignored entirely.
  assign w_deq        = core_yumi_in && !w_empty;
  // A full FIFO can still take the word if the head leaves in the same cycle.
  assign w_enq        = w_beat3 && (!w_full || w_deq);
  assign w_word       = {io_data_in_ch1, io_data_in_ch0, r_asm};
  assign w_batch_inc  = r_batch + BW'(1);
  assign w_batch_wrap = (w_batch_inc == BW'(TOKEN_BATCH));

  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step     <= '0;
      r_asm      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_recv_cnt <= '0;
      r_batch    <= '0;
      r_token    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (io_valid_in) begin
        r_step <= r_step + 2'd1;
        case (r_step)
          2'd0:    r_asm[15:0]  <= {io_data_in_ch1, io_data_in_ch0};
          2'd1:    r_asm[31:16] <= {io_data_in_ch1, io_data_in_ch0};
          2'd2:    r_asm[47:32] <= {io_data_in_ch1, io_data_in_ch0};
          default: ;
        endcase
      end

      if (w_enq) begin
        r_wr_ptr   <= r_wr_ptr + PW'(1);
        r_recv_cnt <= r_recv_cnt + 7'd1;
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);

      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase

      if (w_beat3 && !w_enq) r_overflow <= 1'b1;

      r_token <= 1'b0;
      if (w_deq) begin
        if (w_batch_wrap) begin
          r_batch <= '0;
          r_token <= 1'b1;
        end else begin
          r_batch <= w_batch_inc;
        end
      end
    end
  end

  assign io_token_out   = r_token;
  assign core_valid_out = !w_empty;
  assign core_data_out  = r_mem[r_rd_ptr];
  assign recv_cnt       = r_recv_cnt;
  assign step           = r_step;
  assign overflow_err   = r_overflow;

endmodule

// File: tb/tb_bsg_downstream_in.sv
// Scoreboard bench for bsg_downstream_in: expected words queued at beat 3,
// popped and compared as the core dequeues them.
module tb_bsg_downstream_in;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_valid_in;
  logic [7:0]  io_data_in_ch0;
  logic [7:0]  io_data_in_ch1;
  logic        io_token_out;
  logic        core_valid_out;
  logic [63:0] core_data_out;
  logic        core_yumi_in;
  logic [6:0]  recv_cnt;
  logic [1:0]  step;
  logic        overflow_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb [$];

  bsg_downstream_in #(.FIFO_DEPTH(4), .TOKEN_BATCH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .io_valid_in   (io_valid_in),
    .io_data_in_ch0(io_data_in_ch0),
    .io_data_in_ch1(io_data_in_ch1),
    .io_token_out  (io_token_out),
    .core_valid_out(core_valid_out),
    .core_data_out (core_data_out),
    .core_yumi_in  (core_yumi_in),
    .recv_cnt      (recv_cnt),
    .step          (step),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  // Sends one word as 4 beats with `gap` idle cycles between beats.
  task automatic send_word(input logic [63:0] w, input int gap,
                           input logic yumi_last, input logic exp_enq);
    for (int k = 0; k < 4; k++) begin
      io_valid_in    = 1'b1;
      io_data_in_ch0 = w[16*k +: 8];
      io_data_in_ch1 = w[16*k+8 +: 8];
      if (k == 3) begin
        core_yumi_in = yumi_last;
        if (exp_enq) sb.push_back(w);
      end
      tick();
      io_valid_in  = 1'b0;
      core_yumi_in = 1'b0;
      if (k < 3) repeat (gap) tick();
    end
  endtask

  task automatic pop_one(output logic [63:0] d, output logic v, output logic tok);
    v = core_valid_out;
    d = core_data_out;
    core_yumi_in = 1'b1;
    tick();
    core_yumi_in = 1'b0;
    tok = io_token_out;
  endtask

  task automatic test_reset();
    rst = 1'b1; io_valid_in = 1'b1; core_yumi_in = 1'b1;
    io_data_in_ch0 = 8'h55; io_data_in_ch1 = 8'hAA;
    tick();
    tick();
    n_checks++;
    if ({core_valid_out, recv_cnt, step, overflow_err, io_token_out} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset: valid=%b recv=%0d step=%0d ovf=%b tok=%b, required all 0",
               core_valid_out, recv_cnt, step, overflow_err, io_token_out);
    end
    rst = 1'b0; io_valid_in = 1'b0; core_yumi_in = 1'b0;
    sb.delete();
  endtask

  task automatic test_single_word();
    logic [63:0] d; logic v, t;
    do_reset();
    send_word(64'h0123456789ABCDEF, 0, 1'b0, 1'b1);
    n_checks++;
    if (core_valid_out !== 1'b1 || core_data_out !== sb[0]) begin
      n_fail++;
      $display("FAIL single_latency: valid=%b data=%h, required 1 %h", core_valid_out, core_data_out, sb[0]);
    end
    n_checks++;
    if (recv_cnt !== 7'd1 || step !== 2'd0) begin
      n_fail++;
      $display("FAIL single_cnt: recv=%0d step=%0d, required 1 0", recv_cnt, step);
    end
    pop_one(d, v, t);
    n_checks++;
    if (d !== sb.pop_front()) begin
      n_fail++;
      $display("FAIL single_pop: got %h, required 0123456789abcdef", d);
    end
    n_checks++;
    if (core_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_empty: valid=%b, required 0", core_valid_out);
    end
  endtask

  task automatic test_gapped();
    logic [63:0] w = 64'h0123456789ABCDEF;
    int bad = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      io_valid_in = 1'b1;
      io_data_in_ch0 = w[16*k +: 8];
      io_data_in_ch1 = w[16*k+8 +: 8];
      tick();
      io_valid_in = 1'b0;
      if (k < 3) begin
        for (int g = 0; g < 2; g++) begin
          io_data_in_ch0 = 8'hFF; io_data_in_ch1 = 8'hFF;
          if (step !== 2'(k + 1) || core_valid_out !== 1'b0) bad++;
          tick();
        end
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL gapped_hold: %0d gap cycles wrong step/valid, required 0", bad);
    end
    sb.push_back(w);
    n_checks++;
    if (core_valid_out !== 1'b1 || core_data_out !== sb.pop_front() || step !== 2'd0) begin
      n_fail++;
      $display("FAIL gapped_word: valid=%b data=%h step=%0d, required 1 %h 0",
               core_valid_out, core_data_out, step, w);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] d, e; logic v, t;
    do_reset();
    for (int i = 1; i <= 5; i++)
      send_word({8'(i), 56'hC0FFEE_1234_5600 + 56'(i)}, 0, 1'b0, i <= 4);
    n_checks++;
    if (recv_cnt !== 7'd4 || overflow_err !== 1'b1 || step !== 2'd0) begin
      n_fail++;
      $display("FAIL ovf_state: recv=%0d ovf=%b step=%0d, required 4 1 0", recv_cnt, overflow_err, step);
    end
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      pop_one(d, v, t);
      n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++;
        $display("FAIL ovf_pop%0d: valid=%b data=%h, required 1 %h", i, v, d, e);
      end
    end
    n_checks++;
    if (core_valid_out !== 1'b0 || overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drain: valid=%b ovf=%b, required 0 1", core_valid_out, overflow_err);
    end
  endtask

  task automatic test_full_simul();
    logic [63:0] d, e; logic v, t;
    do_reset();
    for (int i = 0; i < 4; i++) send_word(64'hA5A5_0000_0000_0000 | 64'(i * 3 + 7), 0, 1'b0, 1'b1);
    e = sb.pop_front();
    n_checks++;
    if (core_data_out !== e) begin
      n_fail++;
      $display("FAIL full_head: got %h, required %h", core_data_out, e);
    end
    send_word(64'hFEED_FACE_DEAD_BEEF, 0, 1'b1, 1'b1);
    n_checks++;
    if (overflow_err !== 1'b0 || recv_cnt !== 7'd5) begin
      n_fail++;
      $display("FAIL full_simul: ovf=%b recv=%0d, required 0 5", overflow_err, recv_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      pop_one(d, v, t);
      n_checks++;
      if (v !== 1'b1 || d !== e) begin
        n_fail++;
        $display("FAIL full_pop%0d: valid=%b data=%h, required 1 %h", i, v, d, e);
      end
    end
    n_checks++;
    if (core_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL full_occ: valid=%b after 4 pops, required 0", core_valid_out);
    end
  endtask

  task automatic test_tokens();
    logic [63:0] d, e; logic v, t;
    int pops = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      core_yumi_in = 1'b1;
      tick();
      core_yumi_in = 1'b0;
      n_checks++;
      if (io_token_out !== 1'b0 || core_valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL tok_empty_yumi: tok=%b valid=%b, required 0 0", io_token_out, core_valid_out);
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) send_word(64'h7000 + 64'(r * 16 + i), 0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
        e = sb.pop_front();
        pop_one(d, v, t);
        pops++;
        n_checks++;
        if (v !== 1'b1 || d !== e || t !== (pops % 2 == 0)) begin
          n_fail++;
          $display("FAIL tok_pop%0d: valid=%b data=%h tok=%b, required 1 %h %b",
                   pops, v, d, t, e, pops % 2 == 0);
        end
      end
      tick();
      n_checks++;
      if (io_token_out !== 1'b0) begin
        n_fail++;
        $display("FAIL tok_width: tok=%b one cycle after pulse window, required 0", io_token_out);
      end
    end
  endtask

  task automatic test_reset_midword();
    logic [63:0] e = 64'h1122334455667788;
    do_reset();
    send_word(64'h0, 0, 1'b0, 1'b0);
    io_valid_in = 1'b1; io_data_in_ch0 = 8'h99; io_data_in_ch1 = 8'h99;
    tick();
    tick();
    io_valid_in = 1'b0;
    n_checks++;
    if (step !== 2'd2 || recv_cnt !== 7'd1) begin
      n_fail++;
      $display("FAIL mid_pre: step=%0d recv=%0d, required 2 1", step, recv_cnt);
    end
    rst = 1'b1; io_valid_in = 1'b1;
    tick();
    rst = 1'b0; io_valid_in = 1'b0;
    sb.delete();
    n_checks++;
    if (step !== 2'd0 || recv_cnt !== 7'd0 || core_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: step=%0d recv=%0d valid=%b, required 0 0 0", step, recv_cnt, core_valid_out);
    end
    send_word(e, 1, 1'b0, 1'b1);
    n_checks++;
    if (core_valid_out !== 1'b1 || core_data_out !== sb.pop_front() || recv_cnt !== 7'd1) begin
      n_fail++;
      $display("FAIL mid_word: valid=%b data=%h recv=%0d, required 1 %h 1",
               core_valid_out, core_data_out, recv_cnt, e);
    end
  endtask

  initial begin
    rst = 1'b1; io_valid_in = 1'b0; core_yumi_in = 1'b0;
    io_data_in_ch0 = 8'h0; io_data_in_ch1 = 8'h0;
    test_reset();
    test_single_word();
    test_gapped();
    test_overflow();
    test_full_simul();
    test_tokens();
    test_reset_midword();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
